mux_rr_arb: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with an internal arbiter and valid/ready handshakes on every input channel and on the output.
- Each cycle it selects one requesting channel, by round-robin or fixed priority according to `mode`, and registers that channel's data plus its index into a single output stage.
- It replaces hand-selected 3:1 and 2:1 data muxes wherever several producers share one consumer.

---
 rtl/mux_rr_arb_if.sv | 26 ++
 rtl/mux_rr_arb.sv | 124 ++++++++++++
 tb/tb_mux_rr_arb.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mux_rr_arb_if.sv
// Handshake bundle for mux_rr_arb: N producer channels fanned into one registered
// consumer stage. The slave modport is the arbiter's view of the bundle.
interface mux_rr_arb_if #(
    parameter int N     = 3,
    parameter int W     = 4,
    parameter int SEL_W = $clog2(N)
);
    logic                 mode;
    logic [N*W-1:0]       in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [W-1:0]         out_data;
    logic [SEL_W-1:0]     out_sel;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  mode, in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output mode, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux_rr_arb.sv
// N-channel registered mux with round-robin / fixed-priority arbitration.
// One output stage; a new beat may load on the same edge the held beat drains.
module mux_rr_arb #(
    parameter int N     = 3,
    parameter int W     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    mux_rr_arb_if.slave   bus
);

    logic [W-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic             load_en_s;
    logic             gnt_any_s;
    logic [SEL_W-1:0] gnt_idx_s;
    logic [N-1:0]     gnt_onehot_s;
    logic [W-1:0]     gnt_data_s;

    // Returns {found, index}; the search starts at 'start' (or 0 when fixed) and wraps.
    function automatic logic [SEL_W:0] find_grant(
        input logic [N-1:0]     req,
        input logic [SEL_W-1:0] start,
        input logic             fixed
    );
        logic             found;
        logic [SEL_W-1:0] g;
        logic [SEL_W-1:0] idx;
        found = 1'b0;
        g     = '0;
        idx   = fixed ? '0 : start;
        for (int k = 0; k < N; k++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                g     = idx;
            end else begin
                found = found;
            end
            idx = (idx == SEL_W'(N - 1)) ? '0 : idx + SEL_W'(1);
        end
        return {found, g};
    endfunction

    function automatic logic [W-1:0] select_data(
        input logic [N*W-1:0]   data,
        input logic [SEL_W-1:0] sel
    );
        logic [W-1:0] d;
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (SEL_W'(i) == sel) begin
                d = data[i*W +: W];
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    assign load_en_s = !out_valid_q || bus.out_ready;

    // Grant: suppressed in reset and while the output stage is stalled.
    always_comb begin
        gnt_any_s    = 1'b0;
        gnt_idx_s    = '0;
        gnt_onehot_s = '0;
        if (!rst && load_en_s) begin
            {gnt_any_s, gnt_idx_s} = find_grant(bus.in_valid, ptr_q, bus.mode);
        end else begin
            gnt_any_s = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            gnt_onehot_s[i] = gnt_any_s && (SEL_W'(i) == gnt_idx_s);
        end
        gnt_data_s = select_data(bus.in_data, gnt_idx_s);
    end

    // Output stage and pointer next-state.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (gnt_any_s) begin
            out_data_d  = gnt_data_s;
            out_sel_d   = gnt_idx_s;
            out_valid_d = 1'b1;
            if (!bus.mode) begin
                ptr_d = (gnt_idx_s == SEL_W'(N - 1)) ? '0 : gnt_idx_s + SEL_W'(1);
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = gnt_onehot_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb (N=3, W=4): hand-computed expectations per step.
module tb_mux_rr_arb;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mux_rr_arb_if #(.N(3), .W(4)) bus ();

    mux_rr_arb #(.N(3), .W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [2:0] v, input logic r);
        bus.mode      = m;
        bus.in_valid  = v;
        bus.out_ready = r;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_sel"},   32'(bus.out_sel),   32'(s));
        chk({tag, "_data"},  32'(bus.out_data),  32'(d));
    endtask

    initial begin
        rst = 1'b1;
        bus.in_data = {4'h3, 4'h2, 4'h1};
        drive(1'b0, 3'b111, 1'b1);
        step();
        step();
        chk_out("reset", 1'b0, 2'd0, 4'h0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'(3'b000));

        rst = 1'b0;
        #1;
        chk("rr_first_ready", 32'(bus.in_ready), 32'(3'b001));
        step(); chk_out("rr0", 1'b1, 2'd0, 4'h1);
        chk("rr_second_ready", 32'(bus.in_ready), 32'(3'b010));
        step(); chk_out("rr1", 1'b1, 2'd1, 4'h2);
        step(); chk_out("rr2", 1'b1, 2'd2, 4'h3);
        step(); chk_out("rr3", 1'b1, 2'd0, 4'h1);
        step(); chk_out("rr4", 1'b1, 2'd1, 4'h2);
        step(); chk_out("rr5", 1'b1, 2'd2, 4'h3);

        // fixed priority; ptr is now 0
        drive(1'b1, 3'b110, 1'b1);
        chk("fp_ready", 32'(bus.in_ready), 32'(3'b010));
        step(); chk_out("fp0", 1'b1, 2'd1, 4'h2);
        step(); chk_out("fp1", 1'b1, 2'd1, 4'h2);
        drive(1'b1, 3'b100, 1'b1);
        chk("fp_ch2_ready", 32'(bus.in_ready), 32'(3'b100));
        step(); chk_out("fp2", 1'b1, 2'd2, 4'h3);

        // backpressure
        bus.in_data = {4'h5, 4'h2, 4'h1};
        #1;
        step(); chk_out("bp_load", 1'b1, 2'd2, 4'h5);
        drive(1'b1, 3'b111, 1'b0);
        chk("bp_ready0", 32'(bus.in_ready), 32'(3'b000));
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("bp_hold", 1'b1, 2'd2, 4'h5);
            chk("bp_ready", 32'(bus.in_ready), 32'(3'b000));
        end
        drive(1'b1, 3'b111, 1'b1);
        chk("bp_release_ready", 32'(bus.in_ready), 32'(3'b001));
        step(); chk_out("bp_release", 1'b1, 2'd0, 4'h1);

        // wrap and skip; ptr still 0
        drive(1'b0, 3'b010, 1'b1);
        chk("ws_single_ready", 32'(bus.in_ready), 32'(3'b010));
        step(); chk_out("ws_ch1", 1'b1, 2'd1, 4'h2);
        drive(1'b0, 3'b011, 1'b1);
        chk("ws_skip_ready", 32'(bus.in_ready), 32'(3'b001));
        step(); chk_out("ws_ch0", 1'b1, 2'd0, 4'h1);
        chk("ws_next_ready", 32'(bus.in_ready), 32'(3'b010));
        step(); chk_out("ws_ch1b", 1'b1, 2'd1, 4'h2);
        drive(1'b0, 3'b001, 1'b1);
        chk("single_req_ready", 32'(bus.in_ready), 32'(3'b001));
        step(); chk_out("single_req", 1'b1, 2'd0, 4'h1);

        // mode switch: ptr=1 must survive a fixed-priority grant to ch2
        drive(1'b1, 3'b100, 1'b1);
        step(); chk_out("ms_fixed", 1'b1, 2'd2, 4'h5);
        drive(1'b0, 3'b111, 1'b1);
        chk("ms_back_ready", 32'(bus.in_ready), 32'(3'b010));
        step(); chk_out("ms_rr", 1'b1, 2'd1, 4'h2);

        // drain
        drive(1'b0, 3'b000, 1'b1);
        chk("drain_ready", 32'(bus.in_ready), 32'(3'b000));
        step(); chk_out("drain", 1'b0, 2'd1, 4'h2);

        // reset mid-operation; ptr is 2 going in
        drive(1'b0, 3'b010, 1'b1);
        step(); chk_out("mr_load", 1'b1, 2'd1, 4'h2);
        drive(1'b0, 3'b000, 1'b0);
        step(); chk_out("mr_stall", 1'b1, 2'd1, 4'h2);
        rst = 1'b1;
        drive(1'b0, 3'b111, 1'b0);
        chk("mr_rst_ready", 32'(bus.in_ready), 32'(3'b000));
        step(); chk_out("mr_reset", 1'b0, 2'd0, 4'h0);
        rst = 1'b0;
        drive(1'b0, 3'b101, 1'b1);
        chk("mr_ptr0_ready", 32'(bus.in_ready), 32'(3'b001));
        drive(1'b0, 3'b100, 1'b1);
        chk("mr_ch2_ready", 32'(bus.in_ready), 32'(3'b100));
        step(); chk_out("mr_ch2", 1'b1, 2'd2, 4'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
